// File: rtl/morningjava_sqrt_pipe.sv
// rtl/morningjava_sqrt_pipe.sv - pipelined non-restoring integer square root with valid/ready and global stall
// Optional corrected remainder output enabled by SQRT_REM_EN.
module morningjava_sqrt_pipe #(
   parameter int G_WIDTH = 8,
   parameter int G_TAG   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [G_WIDTH-1:0]   in_data,
   input  logic [G_TAG-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [G_WIDTH/2-1:0] out_root,
   output logic [G_TAG-1:0]     out_tag
`ifdef SQRT_REM_EN
   ,
   output logic [G_WIDTH/2:0]   out_rem
`endif
);

   localparam int N = G_WIDTH / 2;

   // Stage s (0..N-1) feeds its ALU; stage N holds the finished q/r.
   logic [G_WIDTH-1:0] r_d   [N];
   logic [N-1:0]       r_q   [N+1];
   logic [N+1:0]       r_r   [N+1];
   logic [G_TAG-1:0]   r_tag [N+1];
   logic [N:0]         r_v;

   logic               r_out_valid;
   logic [N-1:0]       r_out_root;
   logic [G_TAG-1:0]   r_out_tag;

   logic [N-1:0]       w_q_nx [N];
   logic [N+1:0]       w_r_nx [N];
   logic               w_en;
   logic               w_unused;

   assign w_en     = ~r_out_valid | out_ready;
   assign in_ready = w_en;

   for (genvar s = 0; s < N; s++) begin : g_alu
      logic [N+1:0] w_x;
      logic [N+1:0] w_y;
      logic [N+1:0] w_alu;
      assign w_x       = {r_r[s][N-1:0], r_d[s][G_WIDTH-1 -: 2]};
      assign w_y       = {r_q[s], r_r[s][N+1], 1'b1};
      assign w_alu     = r_r[s][N+1] ? (w_x + w_y) : (w_x - w_y);
      assign w_r_nx[s] = w_alu;
      assign w_q_nx[s] = {r_q[s][N-2:0], ~w_alu[N+1]};
   end

`ifdef SQRT_REM_EN
   logic [N:0]   r_out_rem;
   logic [N+1:0] w_rem_full;
   // A negative final partial remainder is one step short: add back 2q+1.
   assign w_rem_full = r_r[N][N+1] ? (r_r[N] + {1'b0, r_q[N], 1'b1}) : r_r[N];
   assign out_rem    = r_out_rem;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s <= N; s++) begin
            r_q[s]   <= '0;
            r_r[s]   <= '0;
            r_tag[s] <= '0;
         end
         for (int s = 0; s < N; s++) begin
            r_d[s] <= '0;
         end
         r_v         <= '0;
         r_out_valid <= 1'b0;
         r_out_root  <= '0;
         r_out_tag   <= '0;
`ifdef SQRT_REM_EN
         r_out_rem   <= '0;
`endif
      end else if (w_en) begin
         r_v[0]   <= in_valid;
         r_d[0]   <= in_data;
         r_q[0]   <= '0;
         r_r[0]   <= '0;
         r_tag[0] <= in_tag;
         for (int s = 0; s < N; s++) begin
            r_v[s+1]   <= r_v[s];
            r_q[s+1]   <= w_q_nx[s];
            r_r[s+1]   <= w_r_nx[s];
            r_tag[s+1] <= r_tag[s];
         end
         for (int s = 0; s < N - 1; s++) begin
            r_d[s+1] <= {r_d[s][G_WIDTH-3:0], 2'b00};
         end
         r_out_valid <= r_v[N];
         r_out_root  <= r_q[N];
         r_out_tag   <= r_tag[N];
`ifdef SQRT_REM_EN
         r_out_rem   <= w_rem_full[N:0];
`endif
      end
   end

   always_comb begin
      w_unused = ^r_d[N-1][G_WIDTH-3:0] ^ ^r_r[N];
      for (int s = 0; s < N; s++) begin
         w_unused = w_unused ^ r_r[s][N];
      end
   end

   assign out_valid = r_out_valid;
   assign out_root  = r_out_root;
   assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_morningjava_sqrt_pipe.sv
// tb/tb_morningjava_sqrt_pipe.sv - scoreboard bench for morningjava_sqrt_pipe (8-bit and 16-bit instances)
// Checks rem outputs only when SQRT_REM_EN is defined.
module tb_morningjava_sqrt_pipe;

   localparam int W = 8;
   localparam int N = W / 2;
   localparam int T = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n = 1'b1;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] in_data;
   logic [T-1:0] in_tag, out_tag;
   logic [N-1:0] out_root;
   logic [N:0]   out_rem;

   logic         in_valid16, in_ready16, out_valid16, out_ready16;
   logic [15:0]  in_data16;
   logic [T-1:0] in_tag16, out_tag16;
   logic [7:0]   out_root16;
   logic [8:0]   out_rem16;

   int checks   = 0;
   int failures = 0;
   bit bp_en    = 1'b0;

   typedef struct {
      logic [N-1:0] root;
      logic [N:0]   rem;
      logic [T-1:0] tag;
   } exp_t;
   exp_t sb[$];
   int   q16[$];

   morningjava_sqrt_pipe #(.G_WIDTH(W), .G_TAG(T)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root), .out_tag(out_tag)
`ifdef SQRT_REM_EN
      , .out_rem(out_rem)
`endif
   );

   morningjava_sqrt_pipe #(.G_WIDTH(16), .G_TAG(T)) u_dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .in_tag(in_tag16),
      .out_valid(out_valid16), .out_ready(out_ready16), .out_root(out_root16), .out_tag(out_tag16)
`ifdef SQRT_REM_EN
      , .out_rem(out_rem16)
`endif
   );

`ifndef SQRT_REM_EN
   assign out_rem   = '0;
   assign out_rem16 = '0;
`endif

   function automatic int isqrt(int x);
      int r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
      end
   endtask

   task automatic push(int data, int tag);
      exp_t e;
      int   r;
      r      = isqrt(data);
      e.root = r[N-1:0];
      e.rem  = 5'(data - r * r);
      e.tag  = tag[T-1:0];
      sb.push_back(e);
   endtask

   // Presents a sample and returns just after the edge that accepted it.
   task automatic send(int data, int tag);
      int n = 0;
      in_valid = 1'b1;
      in_data  = data[W-1:0];
      in_tag   = tag[T-1:0];
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
      push(data, tag);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", sb.size(), 0);
   endtask

   always @(posedge clk) begin
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   logic         hold_chk = 1'b0;
   logic [N-1:0] prev_root;
   logic [T-1:0] prev_tag;
   logic [N:0]   prev_rem;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_chk = 1'b0;
      end else begin
         check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
         if (hold_chk) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_root", 32'(out_root), 32'(prev_root));
            check("hold_tag", 32'(out_tag), 32'(prev_tag));
`ifdef SQRT_REM_EN
            check("hold_rem", 32'(out_rem), 32'(prev_rem));
`endif
         end
         hold_chk  = out_valid && !out_ready;
         prev_root = out_root;
         prev_tag  = out_tag;
         prev_rem  = out_rem;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("root", 32'(out_root), 32'(e.root));
               check("tag", 32'(out_tag), 32'(e.tag));
`ifdef SQRT_REM_EN
               check("rem", 32'(out_rem), 32'(e.rem));
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid16 && out_ready16) begin
         if (q16.size() == 0) begin
            check("spurious_out16", 32'(out_valid16), 32'd0);
         end else begin
            int x;
            int r;
            x = q16.pop_front();
            r = int'(out_root16);
            check("root16_low", 32'(r * r <= x), 32'd1);
            check("root16_high", 32'((r + 1) * (r + 1) > x), 32'd1);
            check("tag16", 32'(out_tag16), 32'(x % 16));
`ifdef SQRT_REM_EN
            check("rem16", 32'(out_rem16), 32'(x - r * r));
`endif
            if (x == 65535) begin
               check("root16_max", 32'(r), 32'd255);
`ifdef SQRT_REM_EN
               check("rem16_max", 32'(out_rem16), 32'd510);
`endif
            end
         end
      end
   end

   initial begin
      int vals[5] = '{0, 1, 144, 255, 3};
      int n;
      in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
      in_valid16 = 1'b0; in_data16 = '0; in_tag16 = '0; out_ready16 = 1'b1;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_root", 32'(out_root), 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
`ifdef SQRT_REM_EN
      check("rst_out_rem", 32'(out_rem), 32'd0);
`endif
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Single sample latency
      send(200, 5);
      in_valid = 1'b0;
      for (int i = 0; i <= N; i++) begin
         @(negedge clk);
         check("lat_low", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      check("lat_high", 32'(out_valid), 32'd1);
      drain();

      // Back-to-back stream
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) send(vals[i], i + 1);
      in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first", 32'(out_valid), 32'd1);
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         check("b2b_consec", 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      check("b2b_end", 32'(out_valid), 32'd0);
      drain();

      // Backpressure
      @(posedge clk);
      #1;
      bp_en = 1'b1;
      for (int i = 0; i < 16; i++) send(int'($urandom_range(0, 255)), i);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      bp_en = 1'b0;
      drain();

      // Asynchronous reset with samples in flight
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send(100 + i, 9 + i);
      in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("mid_valid_seen", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_root", 32'(out_root), 32'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < N + 3; i++) begin
         @(negedge clk);
         check("post_rst_quiet", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      send(49, 3);
      in_valid = 1'b0;
      drain();

      // Bubble pattern
      for (int j = 0; j < 16 + N + 3; j++) begin
         int k;
         @(posedge clk);
         #1;
         if (j < 16 && (j % 2 == 0)) begin
            in_valid = 1'b1;
            in_data  = W'(j * 13);
            in_tag   = T'(j);
            push(j * 13, j % 16);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         k = j - N - 2;
         check("bubble_pattern", 32'(out_valid), 32'((k >= 0 && k < 16) ? (k % 2 == 0) : 0));
      end
      drain();

      // 16-bit exhaustive sweep
      @(posedge clk);
      #1;
      for (int x = 0; x < 65536; x++) begin
         in_valid16 = 1'b1;
         in_data16  = 16'(x);
         in_tag16   = T'(x % 16);
         q16.push_back(x);
         @(posedge clk);
         #1;
      end
      in_valid16 = 1'b0;
      n = 0;
      while (q16.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain16_empty", q16.size(), 0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
